// File: rtl/mult_acc_pkg.sv
// Shared constants and elaboration helpers for the multiply-accumulate tree:
// log2 sizing, pipeline latency, per-level operand widths and the bit offsets
// of each stage inside the flattened inter-stage bus.
package mult_acc_pkg;

    // Sideband bits that travel with every beat through the pipeline.
    typedef struct packed {
        logic valid;
        logic last;
        logic sgn;
    } beat_tag_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 32'sd0;
        span   = 32'sd1;
        while (span < value) begin
            span   = span << 1;
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Edges from the accepting edge to out_valid: input capture, multiply,
    // one register per tree level, accumulate.
    function automatic int lat(input int num_mac);
        return clog2(num_mac) + 32'sd2;
    endfunction

    // Operand width entering tree level 'level'; level 0 sees raw products.
    function automatic int level_width(input int word_size, input int level);
        return 32'sd2 * word_size + level;
    endfunction

    // Bit offset of stage 'stage' in the flattened bus. Stage 0 holds the
    // products, stage k holds the outputs of tree level k-1.
    function automatic int stage_off(input int num_mac, input int word_size, input int stage);
        int off;
        off = 32'sd0;
        for (int j = 0; j < stage; j++) begin
            off = off + (num_mac >> j) * level_width(word_size, j);
        end
        return off;
    endfunction

endpackage

// File: rtl/mult_acc_tree_level.sv
// One registered level of the binary adder tree. Adjacent pairs are extended
// by one bit (sign or zero, following the beat's signedness) and summed, so
// no level can overflow. The beat tag rides along with the data.
module mult_acc_tree_level
    import mult_acc_pkg::*;
#(
    parameter int PAIRS = 1,
    parameter int IN_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv,
    input  logic [2*PAIRS*IN_W-1:0]  pair_data,
    input  beat_tag_t                pair_tag,
    output logic [PAIRS*(IN_W+1)-1:0] sum_data,
    output beat_tag_t                sum_tag
);

    logic [PAIRS*(IN_W+1)-1:0] sum_s;
    logic [PAIRS*(IN_W+1)-1:0] sum_data_r;
    beat_tag_t                 sum_tag_r;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [IN_W-1:0] lo_s;
        logic [IN_W-1:0] hi_s;
        assign lo_s = pair_data[2*p*IN_W +: IN_W];
        assign hi_s = pair_data[(2*p+1)*IN_W +: IN_W];
        assign sum_s[p*(IN_W+1) +: IN_W+1] = {pair_tag.sgn & lo_s[IN_W-1], lo_s}
                                           + {pair_tag.sgn & hi_s[IN_W-1], hi_s};
    end

    // Register the pair sums and tag; the whole pipeline stalls together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_data_r <= '0;
            sum_tag_r  <= '0;
        end else if (adv) begin
            sum_data_r <= sum_s;
            sum_tag_r  <= pair_tag;
        end
    end

    assign sum_data = sum_data_r;
    assign sum_tag  = sum_tag_r;

endmodule

// File: rtl/mult_acc_tree.sv
// Multiply-accumulate tree: NUM_MAC lane products reduced by a pipelined
// binary adder tree, then accumulated across a burst of beats delimited by
// in_last. Result handshake back-pressures the whole pipeline.
// Optional feature: define MULT_ACC_SATURATE_EN to clamp the accumulator on
// overflow instead of wrapping modulo 2^ACC_SIZE.
module mult_acc_tree
    import mult_acc_pkg::*;
#(
    parameter int NUM_MAC   = 256,
    parameter int WORD_SIZE = 8,
    parameter int ACC_SIZE  = 32,
    parameter int CNT_SIZE  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MAC*WORD_SIZE-1:0]  vec_bus_in,
    input  logic [NUM_MAC*WORD_SIZE-1:0]  stat_op_bus_in,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic                          in_signed,
    output logic                          in_ready,
    output logic [ACC_SIZE-1:0]           sum_out,
    output logic [CNT_SIZE-1:0]           cnt_out,
    output logic                          ovf_out,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int LEVELS = clog2(NUM_MAC);
    localparam int PROD_W = level_width(WORD_SIZE, 0);
    localparam int TREE_W = level_width(WORD_SIZE, LEVELS);
    localparam int BUS_W  = stage_off(NUM_MAC, WORD_SIZE, LEVELS + 1);
    localparam int EXT_W  = ACC_SIZE + 2;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};
`ifdef MULT_ACC_SATURATE_EN
    localparam logic [ACC_SIZE-1:0] UNS_MAX = {ACC_SIZE{1'b1}};
    localparam logic [ACC_SIZE-1:0] SGN_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] SGN_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};
`endif

    logic                          adv_s;
    logic [NUM_MAC*WORD_SIZE-1:0]  vec_r;
    logic [NUM_MAC*WORD_SIZE-1:0]  stat_r;
    beat_tag_t                     in_tag_r;
    logic [NUM_MAC*PROD_W-1:0]     prod_s;
    logic [NUM_MAC*PROD_W-1:0]     prod_r;
    beat_tag_t                     mult_tag_r;
    logic [BUS_W-1:0]              stage_bus_s;
    beat_tag_t                     stage_tag_s [0:LEVELS];

    logic [TREE_W-1:0]             tree_s;
    beat_tag_t                     tree_tag_s;
    logic [EXT_W-1:0]              tree_ext_s;
    logic [ACC_SIZE-1:0]           base_s;
    logic [EXT_W-1:0]              base_ext_s;
    logic [EXT_W-1:0]              total_s;
    logic                          ovf_now_s;
    logic [ACC_SIZE-1:0]           result_s;
    logic [CNT_SIZE-1:0]           cnt_next_s;
    logic                          ovf_next_s;

    logic [ACC_SIZE-1:0]           acc_r;
    logic [CNT_SIZE-1:0]           cnt_r;
    logic                          ovf_r;
    logic                          in_burst_r;
    logic [ACC_SIZE-1:0]           sum_out_r;
    logic [CNT_SIZE-1:0]           cnt_out_r;
    logic                          ovf_out_r;
    logic                          out_valid_r;

    // A held result stalls every stage; consuming it frees the pipe that edge.
    assign adv_s    = !out_valid_r | out_ready;
    assign in_ready = adv_s;

    // Capture the offered beat; an idle slot enters the pipe as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_r    <= '0;
            stat_r   <= '0;
            in_tag_r <= '0;
        end else if (adv_s) begin
            vec_r    <= vec_bus_in;
            stat_r   <= stat_op_bus_in;
            in_tag_r <= beat_tag_t'{valid: in_valid, last: in_last, sgn: in_signed};
        end
    end

    // Per-lane products: extend both operands to full product width so the
    // low PROD_W bits of an unsigned multiply are right for either signedness.
    for (genvar i = 0; i < NUM_MAC; i++) begin : g_lane
        logic [PROD_W-1:0] a_ext_s;
        logic [PROD_W-1:0] b_ext_s;
        assign a_ext_s = {{WORD_SIZE{in_tag_r.sgn & vec_r[(i+1)*WORD_SIZE-1]}},
                          vec_r[i*WORD_SIZE +: WORD_SIZE]};
        assign b_ext_s = {{WORD_SIZE{in_tag_r.sgn & stat_r[(i+1)*WORD_SIZE-1]}},
                          stat_r[i*WORD_SIZE +: WORD_SIZE]};
        assign prod_s[i*PROD_W +: PROD_W] = a_ext_s * b_ext_s;
    end

    // Multiply stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r     <= '0;
            mult_tag_r <= '0;
        end else if (adv_s) begin
            prod_r     <= prod_s;
            mult_tag_r <= in_tag_r;
        end
    end

    assign stage_bus_s[NUM_MAC*PROD_W-1:0] = prod_r;
    assign stage_tag_s[0]                  = mult_tag_r;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int IN_W    = level_width(WORD_SIZE, k);
        localparam int PAIRS   = NUM_MAC >> (k + 1);
        localparam int IN_OFF  = stage_off(NUM_MAC, WORD_SIZE, k);
        localparam int OUT_OFF = stage_off(NUM_MAC, WORD_SIZE, k + 1);

        mult_acc_tree_level #(
            .PAIRS (PAIRS),
            .IN_W  (IN_W)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv_s),
            .pair_data (stage_bus_s[IN_OFF +: 2*PAIRS*IN_W]),
            .pair_tag  (stage_tag_s[k]),
            .sum_data  (stage_bus_s[OUT_OFF +: PAIRS*(IN_W+1)]),
            .sum_tag   (stage_tag_s[k+1])
        );
    end

    assign tree_s     = stage_bus_s[stage_off(NUM_MAC, WORD_SIZE, LEVELS) +: TREE_W];
    assign tree_tag_s = stage_tag_s[LEVELS];

    // Accumulate with two guard bits so range violations are visible for
    // both signed and unsigned interpretation of the beat.
    always_comb begin
        tree_ext_s = {{(EXT_W-TREE_W){tree_tag_s.sgn & tree_s[TREE_W-1]}}, tree_s};
        base_s     = in_burst_r ? acc_r : '0;
        base_ext_s = {{2{tree_tag_s.sgn & base_s[ACC_SIZE-1]}}, base_s};
        total_s    = base_ext_s + tree_ext_s;
        if (tree_tag_s.sgn) begin
            ovf_now_s = !((total_s[EXT_W-1:ACC_SIZE-1] == 3'b000) ||
                          (total_s[EXT_W-1:ACC_SIZE-1] == 3'b111));
        end else begin
            ovf_now_s = (total_s[EXT_W-1:ACC_SIZE] != 2'b00);
        end
`ifdef MULT_ACC_SATURATE_EN
        if (!ovf_now_s) begin
            result_s = total_s[ACC_SIZE-1:0];
        end else if (!tree_tag_s.sgn) begin
            result_s = UNS_MAX;
        end else if (total_s[EXT_W-1]) begin
            result_s = SGN_MIN;
        end else begin
            result_s = SGN_MAX;
        end
`else
        result_s = total_s[ACC_SIZE-1:0];
`endif
        cnt_next_s = cnt_r + CNT_ONE;
        ovf_next_s = (in_burst_r & ovf_r) | ovf_now_s;
    end

    // Accumulate/output stage: bubbles leave state alone; the last beat
    // publishes the result and clears the accumulator for the next burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            in_burst_r  <= 1'b0;
            sum_out_r   <= '0;
            cnt_out_r   <= '0;
            ovf_out_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (adv_s) begin
            if (tree_tag_s.valid && tree_tag_s.last) begin
                sum_out_r   <= result_s;
                cnt_out_r   <= cnt_next_s;
                ovf_out_r   <= ovf_next_s;
                out_valid_r <= 1'b1;
                acc_r       <= '0;
                cnt_r       <= '0;
                ovf_r       <= 1'b0;
                in_burst_r  <= 1'b0;
            end else if (tree_tag_s.valid) begin
                acc_r       <= result_s;
                cnt_r       <= cnt_next_s;
                ovf_r       <= ovf_next_s;
                in_burst_r  <= 1'b1;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign sum_out   = sum_out_r;
    assign cnt_out   = cnt_out_r;
    assign ovf_out   = ovf_out_r;
    assign out_valid = out_valid_r;

endmodule

// File: doc/mult_acc_tree.md
MULT_ACC_TREE -- requirements
Module: mult_acc_tree

Interface
REQ-001 SHALL have parameter NUM_MAC, default 256, lane count; power of two, >= 2.
REQ-002 SHALL have parameter WORD_SIZE, default 8, operand width per lane.
REQ-003 SHALL have parameter ACC_SIZE, default 32, accumulator width; >= 2*WORD_SIZE+log2(NUM_MAC)+1.
REQ-004 SHALL have parameter CNT_SIZE, default 16, beat-counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port vec_bus_in, input, NUM_MAC*WORD_SIZE, vector operands; lane i occupies bits [(i+1)*WORD_SIZE-1 -: WORD_SIZE].
REQ-008 SHALL have port stat_op_bus_in, input, NUM_MAC*WORD_SIZE, stationary operands, same lane packing.
REQ-009 SHALL have port in_valid, input, 1, beat present.
REQ-010 SHALL have port in_last, input, 1, final beat of burst.
REQ-011 SHALL have port in_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-012 SHALL have port in_ready, output, 1, beat accepted when in_valid & in_ready.
REQ-013 SHALL have port sum_out, output, ACC_SIZE, burst result.
REQ-014 SHALL have port cnt_out, output, CNT_SIZE, number of beats in burst.
REQ-015 SHALL have port ovf_out, output, 1, sticky accumulator overflow for the burst.
REQ-016 SHALL have ports out_valid (output, 1) and out_ready (input, 1), result handshake.

Function
REQ-017 SHALL pipeline: 1 multiply stage, log2(NUM_MAC) binary adder-tree stages, 1 accumulate/output stage; LAT = log2(NUM_MAC)+2 edges.
REQ-018 SHALL assert out_valid LAT edges after the edge accepting an in_last beat.
REQ-019 SHALL size products at 2*WORD_SIZE and widen each tree level by 1 bit; no tree overflow.
REQ-020 SHALL sign- or zero-extend per in_signed; in_signed travels with its beat through the pipeline.
REQ-021 SHALL load the accumulator on a burst's first beat and add on later beats; cnt increments per beat and wraps at 2^CNT_SIZE.
REQ-022 SHALL on the last beat present acc+tree_sum on sum_out, set out_valid, and clear the accumulator so the next beat starts a new burst.
REQ-023 SHALL advance the whole pipeline only when adv = !out_valid | out_ready; in_ready = adv; all stages hold when !adv.
REQ-024 SHALL hold sum_out, cnt_out, ovf_out stable while out_valid & !out_ready.
REQ-025 SHALL accept a new beat on the edge the result handshakes (no bubble).
REQ-026 SHALL propagate invalid pipeline slots as bubbles that leave accumulator and count unchanged.
REQ-027 SHALL set ovf when an accumulate exceeds ACC_SIZE range for the beat's signedness; ovf clears with the accumulator.

Reset
REQ-028 SHALL on rst low clear all pipeline valids, accumulator, counter and ovf immediately; sum_out=0, cnt_out=0, ovf_out=0, out_valid=0, in_ready=1 after release.
REQ-029 SHALL discard any partial burst on mid-operation reset.

Configuration
REQ-030 SHALL, with MULT_ACC_SATURATE_EN defined, clamp the accumulator to the max/min of its signedness on overflow.
REQ-031 SHALL, without MULT_ACC_SATURATE_EN, wrap modulo 2^ACC_SIZE; ovf_out still reports.

Structure
REQ-032 SHALL place the clog2 function, LAT derivation and level-width constants in package mult_acc_pkg.
REQ-033 SHALL implement one tree level as sub-module mult_acc_tree_level (parameters: pair count, input width), instantiated log2(NUM_MAC) times.

Verification (NUM_MAC=4, WORD_SIZE=8, ACC_SIZE=20, out_ready=1 unless stated)
REQ-034 SHALL check: unsigned single beat, all lanes 255x255, in_last -> after 4 edges sum_out=260100, cnt_out=1, ovf_out=0.
REQ-035 SHALL check: signed, lanes -128x127, single beat -> sum_out=-65024 (two's complement, 20 bits).
REQ-036 SHALL check: unsigned 5-beat burst of 255x255 -> with macro sum_out=1048575, ovf_out=1; without macro sum_out=251924, ovf_out=1.
REQ-037 SHALL check: back-to-back bursts of 3 beats, out_ready low 3 cycles on first result -> in_ready low, sum_out stable, second result correct, no beat lost.
REQ-038 SHALL check: rst low after 2 beats of a burst -> all outputs 0; next 1-beat burst of 1x1 lanes -> sum_out=4, cnt_out=1.
